// File: rtl/invcipher_if.sv
// Handshake and data bundle between the bus wrapper (master) and the
// AES-128 inverse cipher core (slave).
interface invcipher_if;
  logic [1407:0] key;
  logic          start;
  logic [127:0]  in;
  logic [127:0]  out;
  logic          busy;
  logic          done;

  modport master (output key, start, in, input out, busy, done);
  modport slave  (input key, start, in, output out, busy, done);
endinterface

// File: rtl/invcipher.sv
// Iterative AES-128 inverse cipher: one inverse round per clock, ten rounds,
// start/busy/done handshake; the expanded key schedule is supplied externally.
module invcipher (
  input logic         clk,
  input logic         rst,
  invcipher_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;
  typedef logic [0:3][7:0]  col_t;
  typedef logic [0:15][7:0] blk_t;

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  // Source byte for each InvShiftRows output byte: row r rotates right by r.
  localparam int ISR_SRC [16] = '{0, 13, 10, 7, 4, 1, 14, 11, 8, 5, 2, 15, 12, 9, 6, 3};

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic col_t inv_mix_col(input col_t a);
    logic [7:0] x2 [4], x4 [4], x8 [4], m9 [4], mb [4], md [4], me [4];
    for (int i = 0; i < 4; i++) begin
      x2[i] = xt(a[i]);
      x4[i] = xt(x2[i]);
      x8[i] = xt(x4[i]);
      m9[i] = x8[i] ^ a[i];
      mb[i] = x8[i] ^ x2[i] ^ a[i];
      md[i] = x8[i] ^ x4[i] ^ a[i];
      me[i] = x8[i] ^ x4[i] ^ x2[i];
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  state_t     state;
  blk_t       s;
  logic [3:0] rnd;

  logic [127:0] rk [0:10];
  blk_t         isr, isb, ark, imc;

  for (genvar g = 0; g < 11; g++) begin : g_rk
    assign rk[g] = bus.key[1407-128*g -: 128];
  end

  for (genvar g = 0; g < 16; g++) begin : g_byte
    assign isr[g] = s[ISR_SRC[g]];
    assign isb[g] = INV_SBOX[isr[g]];
  end

  assign ark = isb ^ rk[rnd];

  for (genvar g = 0; g < 4; g++) begin : g_col
    assign imc[4*g +: 4] = inv_mix_col(ark[4*g +: 4]);
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values; blocking here would chain updates in order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      s        <= '0;
      rnd      <= '0;
      bus.out  <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            s        <= bus.in ^ rk[10];
            rnd      <= 4'd9;
            bus.busy <= 1'b1;
            state    <= ROUND;
          end
        end
        ROUND: begin
          s   <= imc;
          rnd <= rnd - 4'd1;
          if (rnd == 4'd1) state <= FINAL;
        end
        FINAL: begin
          // rnd has reached 0 here, so ark already carries round key 0.
          bus.out  <= ark;
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_invcipher.sv
// Self-checking bench for invcipher: FIPS-197 vectors, handshake corner cases
// and random blocks encrypted by an independent forward-cipher model.
module tb_invcipher;

  logic clk = 1'b0;
  logic rst = 1'b0;
  invcipher_if bus();

  invcipher dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] sbox [256];

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

  // ---------------- reference model (forward AES from field arithmetic) ----
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00, r, acc;
      if (x != 0)
        for (int y = 1; y < 256; y++)
          if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      r = inv;
      acc = inv;
      repeat (4) begin
        r = {r[6:0], r[7]};
        acc = acc ^ r;
      end
      sbox[x] = acc ^ 8'h63;
    end
  endtask

  function automatic logic [1407:0] expand_key(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcon = 8'h01;
    logic [1407:0] ks;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
        t[31:24] = t[31:24] ^ rcon;
        rcon = xt(rcon);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 44; i++) ks[1407-32*i -: 32] = w[i];
    return ks;
  endfunction

  function automatic logic [127:0] encrypt(input logic [127:0] pt, input logic [1407:0] ks);
    logic [7:0] st [16];
    logic [7:0] t  [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] v;
    v = pt ^ ks[1407 -: 128];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) st[i] = sbox[v[127-8*i -: 8]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++)
          t[row+4*c] = st[row+4*((c+row)%4)];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (r < 10) begin
          st[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          st[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          st[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          st[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end else begin
          st[4*c] = a0; st[4*c+1] = a1; st[4*c+2] = a2; st[4*c+3] = a3;
        end
      end
      for (int i = 0; i < 16; i++) v[127-8*i -: 8] = st[i];
      v = v ^ ks[1407-128*r -: 128];
    end
    return v;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- stimulus helpers --------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulses start for one edge, then waits (bounded) for done. Returns in the
  // done cycle so a caller can start the next block with no bubble.
  task automatic run_block(input logic [1407:0] ks, input logic [127:0] ct,
                           input logic [127:0] hold_val, input bit check_hold,
                           output int lat, output int busy_cnt, output int hold_bad);
    bus.key   = ks;
    bus.in    = ct;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    bus.in    = rand128();
    lat = -1;
    busy_cnt = 0;
    hold_bad = 0;
    for (int i = 1; i <= 40; i++) begin
      if (bus.busy) busy_cnt++;
      if (check_hold && bus.out !== hold_val) hold_bad++;
      step();
      if (bus.done) begin
        lat = i;
        break;
      end
    end
  endtask

  // ---------------- scenarios ---------------------------------------------
  task automatic test_reset();
    rst = 1'b0;
    bus.start = 1'b0;
    bus.in = '0;
    bus.key = '0;
    repeat (3) step();
    n_tests++;
    if (bus.out !== 128'h0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: out=%h busy=%b done=%b, want out=0 busy=0 done=0",
               bus.out, bus.busy, bus.done);
    end
    rst = 1'b1;
    step();
  endtask

  task automatic test_fips_c1();
    logic [1407:0] ks = expand_key(C1_KEY);
    int lat, bc, hb;
    n_tests++;
    if (ks[127:0] !== C1_RK10) begin
      n_fail++;
      $display("FAIL c1_model_rk10: got %h want %h", ks[127:0], C1_RK10);
    end
    run_block(ks, C1_CT, '0, 1'b0, lat, bc, hb);
    n_tests++;
    if (lat != 10) begin n_fail++; $display("FAIL c1_latency: got %0d want 10", lat); end
    n_tests++;
    if (bc != 10) begin n_fail++; $display("FAIL c1_busy_cycles: got %0d want 10", bc); end
    n_tests++;
    if (bus.out !== C1_PT) begin n_fail++; $display("FAIL c1_out: got %h want %h", bus.out, C1_PT); end
    n_tests++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL c1_busy_at_done: got %b want 0", bus.busy); end
    step();
    n_tests++;
    if (bus.done !== 1'b0) begin n_fail++; $display("FAIL c1_done_width: done still %b one cycle later", bus.done); end
  endtask

  task automatic test_fips_b();
    int lat, bc, hb;
    run_block(expand_key(B_KEY), B_CT, '0, 1'b0, lat, bc, hb);
    n_tests++;
    if (lat != 10) begin n_fail++; $display("FAIL b_latency: got %0d want 10", lat); end
    n_tests++;
    if (bus.out !== B_PT) begin n_fail++; $display("FAIL b_out: got %h want %h", bus.out, B_PT); end
    step();
  endtask

  task automatic test_back_to_back();
    int lat, bc, hb;
    run_block(expand_key(C1_KEY), C1_CT, '0, 1'b0, lat, bc, hb);
    n_tests++;
    if (lat != 10 || bus.out !== C1_PT) begin
      n_fail++;
      $display("FAIL b2b_first: lat=%0d out=%h want lat=10 out=%h", lat, bus.out, C1_PT);
    end
    run_block(expand_key(B_KEY), B_CT, C1_PT, 1'b1, lat, bc, hb);
    n_tests++;
    if (lat != 10) begin n_fail++; $display("FAIL b2b_second_latency: got %0d want 10", lat); end
    n_tests++;
    if (hb != 0) begin n_fail++; $display("FAIL b2b_out_hold: %0d cycles out changed, want 0", hb); end
    n_tests++;
    if (bus.out !== B_PT) begin n_fail++; $display("FAIL b2b_second_out: got %h want %h", bus.out, B_PT); end
    step();
  endtask

  task automatic test_start_during_busy();
    int pulses = 0;
    int done_at = -1;
    logic [127:0] out_at = '0;
    bus.key = expand_key(C1_KEY);
    bus.in = C1_CT;
    bus.start = 1'b1;
    step();
    for (int k = 1; k <= 25; k++) begin
      bus.start = (k == 3 || k == 7);
      bus.in = rand128();
      step();
      if (bus.done) begin
        pulses++;
        if (pulses == 1) begin
          done_at = k;
          out_at = bus.out;
        end
      end
    end
    bus.start = 1'b0;
    n_tests++;
    if (pulses != 1) begin n_fail++; $display("FAIL busy_start_pulses: got %0d want 1", pulses); end
    n_tests++;
    if (done_at != 10) begin n_fail++; $display("FAIL busy_start_latency: got %0d want 10", done_at); end
    n_tests++;
    if (out_at !== C1_PT) begin n_fail++; $display("FAIL busy_start_out: got %h want %h", out_at, C1_PT); end
  endtask

  task automatic test_reset_mid_op();
    int stray = 0;
    int lat, bc, hb;
    bus.key = expand_key(B_KEY);
    bus.in = B_CT;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (5) step();
    rst = 1'b0;
    step();
    n_tests++;
    if (bus.out !== 128'h0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_state: out=%h busy=%b done=%b, want out=0 busy=0 done=0",
               bus.out, bus.busy, bus.done);
    end
    rst = 1'b1;
    repeat (20) begin
      step();
      if (bus.done) stray++;
    end
    n_tests++;
    if (stray != 0) begin n_fail++; $display("FAIL midreset_stray_done: got %0d pulses want 0", stray); end
    run_block(expand_key(C1_KEY), C1_CT, '0, 1'b0, lat, bc, hb);
    n_tests++;
    if (lat != 10 || bus.out !== C1_PT) begin
      n_fail++;
      $display("FAIL midreset_recover: lat=%0d out=%h want lat=10 out=%h", lat, bus.out, C1_PT);
    end
    step();
  endtask

  task automatic test_random();
    int lat, bc, hb;
    logic [127:0] k, pt, ct;
    for (int n = 0; n < 1000; n++) begin
      logic [1407:0] ks;
      k  = rand128();
      pt = rand128();
      ks = expand_key(k);
      ct = encrypt(pt, ks);
      run_block(ks, ct, '0, 1'b0, lat, bc, hb);
      n_tests++;
      if (lat != 10) begin n_fail++; $display("FAIL rand_latency[%0d]: got %0d want 10", n, lat); end
      n_tests++;
      if (bus.out !== pt) begin
        n_fail++;
        $display("FAIL rand_out[%0d]: key=%h ct=%h got %h want %h", n, k, ct, bus.out, pt);
      end
    end
    step();
  endtask

  initial begin
    bus.start = 1'b0;
    bus.in = '0;
    bus.key = '0;
    build_sbox();
    test_reset();
    test_fips_c1();
    test_fips_b();
    test_back_to_back();
    test_start_during_busy();
    test_reset_mid_op();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
